// File: rtl/flag_pkg.sv
// Shared flag-register definitions: flag bit positions and the branch condition codes.
package flag_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_C = 3;

    typedef enum logic [3:0] {
        COND_EQ = 4'd0,
        COND_NE = 4'd1,
        COND_CS = 4'd2,
        COND_CC = 4'd3,
        COND_MI = 4'd4,
        COND_PL = 4'd5,
        COND_VS = 4'd6,
        COND_VC = 4'd7,
        COND_HI = 4'd8,
        COND_LS = 4'd9,
        COND_GE = 4'd10,
        COND_LT = 4'd11,
        COND_GT = 4'd12,
        COND_LE = 4'd13,
        COND_AL = 4'd14,
        COND_NV = 4'd15
    } cond_e;

endpackage

// File: rtl/flag_stack_reg_if.sv
// Control/status bundle between the ALU/control unit and the flag register.
interface flag_stack_reg_if #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [NFLAGS-1:0] flag_in;
    logic              wr_en;
    logic [NFLAGS-1:0] wr_mask;
    logic              push;
    logic              pop;
    logic              err_clr;
    logic [3:0]        cond_sel;
    logic [NFLAGS-1:0] flags;
    logic [DW-1:0]     depth;
    logic              full;
    logic              empty;
    logic              ovf_err;
    logic              unf_err;
    logic              cond_true;

    modport master (
        output flag_in, wr_en, wr_mask, push, pop, err_clr, cond_sel,
        input  flags, depth, full, empty, ovf_err, unf_err, cond_true
    );

    modport slave (
        input  flag_in, wr_en, wr_mask, push, pop, err_clr, cond_sel,
        output flags, depth, full, empty, ovf_err, unf_err, cond_true
    );
endinterface

// File: rtl/flag_cond_eval.sv
// Combinational branch-condition decoder over the Z/N/V/C flags.
module flag_cond_eval
    import flag_pkg::*;
(
    input  logic [3:0] cond_sel,
    input  logic [3:0] flags,
    output logic       cond_true
);
    logic z, n, v, c;

    assign z = flags[FLAG_Z];
    assign n = flags[FLAG_N];
    assign v = flags[FLAG_V];
    assign c = flags[FLAG_C];

    always_comb begin
        cond_true = 1'b0;
        case (cond_e'(cond_sel))
            COND_EQ: cond_true = z;
            COND_NE: cond_true = ~z;
            COND_CS: cond_true = c;
            COND_CC: cond_true = ~c;
            COND_MI: cond_true = n;
            COND_PL: cond_true = ~n;
            COND_VS: cond_true = v;
            COND_VC: cond_true = ~v;
            COND_HI: cond_true = c & ~z;
            COND_LS: cond_true = ~c | z;
            COND_GE: cond_true = (n == v);
            COND_LT: cond_true = (n != v);
            COND_GT: cond_true = ~z & (n == v);
            COND_LE: cond_true = z | (n != v);
            COND_AL: cond_true = 1'b1;
            COND_NV: cond_true = 1'b0;
            default: cond_true = 1'b0;
        endcase
    end
endmodule

// File: rtl/flag_stack_reg.sv
// Status-flag register with masked writes, a LIFO save stack and condition evaluation.
// State advances on the falling clock edge (CPU control phase).
module flag_stack_reg
    import flag_pkg::*;
#(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst_n,
    flag_stack_reg_if.slave  bus
);
    localparam int DW = $clog2(DEPTH + 1);

    logic [NFLAGS-1:0] flags_q;
    logic [NFLAGS-1:0] stack_q [DEPTH];
    logic [DW-1:0]     depth_q;
    logic              ovf_q;
    logic              unf_q;

    logic              is_full, is_empty;
    logic              push_only, pop_only, xchg;
    logic              do_push, do_pop, do_store, do_restore;
    logic              ovf_set, unf_set;
    logic [DW-1:0]     top_idx, store_idx;
    logic [NFLAGS-1:0] top_entry, base_flags, next_flags;

    assign is_full  = (depth_q == DW'(DEPTH));
    assign is_empty = (depth_q == '0);

    // push+pop on an empty stack degrades to a plain push
    assign push_only = bus.push & (~bus.pop | is_empty);
    assign pop_only  = bus.pop & ~bus.push;
    assign xchg      = bus.push & bus.pop & ~is_empty;

    assign do_push    = push_only & ~is_full;
    assign ovf_set    = push_only & is_full;
    assign do_pop     = pop_only & ~is_empty;
    assign unf_set    = pop_only & is_empty;
    assign do_store   = do_push | xchg;
    assign do_restore = do_pop | xchg;

    assign top_idx   = depth_q - DW'(1);
    assign store_idx = do_push ? depth_q : top_idx;

    always_comb begin
        top_entry = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (DW'(i) == top_idx) top_entry = stack_q[i];
        end
    end

    // restored value first, then ALU write overrides the masked bits
    always_comb begin
        base_flags = do_restore ? top_entry : flags_q;
        next_flags = base_flags;
        if (bus.wr_en) next_flags = (base_flags & ~bus.wr_mask) | (bus.flag_in & bus.wr_mask);
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
        end else begin
            flags_q <= next_flags;
            if (do_push)     depth_q <= depth_q + DW'(1);
            else if (do_pop) depth_q <= depth_q - DW'(1);
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (do_store && (DW'(i) == store_idx)) stack_q[i] <= flags_q;
            end
            ovf_q <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q <= unf_set | (unf_q & ~bus.err_clr);
        end
    end

    flag_cond_eval u_cond (
        .cond_sel  (bus.cond_sel),
        .flags     (flags_q[3:0]),
        .cond_true (bus.cond_true)
    );

    assign bus.flags   = flags_q;
    assign bus.depth   = depth_q;
    assign bus.full    = is_full;
    assign bus.empty   = is_empty;
    assign bus.ovf_err = ovf_q;
    assign bus.unf_err = unf_q;
endmodule

// File: tb/tb_flag_stack_reg.sv
// Bench for flag_stack_reg: directed scenarios plus random traffic against a queue-based model.
module tb_flag_stack_reg;
    localparam int NFLAGS = 4;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    flag_stack_reg_if #(.NFLAGS(NFLAGS), .DEPTH(DEPTH)) bus ();

    flag_stack_reg #(.NFLAGS(NFLAGS), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial forever #50 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    logic [3:0] m_flags = '0;
    logic [3:0] m_q[$];
    bit         m_ovf = 1'b0;
    bit         m_unf = 1'b0;

    // Conditions come in complementary pairs: odd code negates the even one.
    function automatic bit mcond(input logic [3:0] code, input logic [3:0] f);
        bit z, n, v, c, r;
        z = f[0]; n = f[1]; v = f[2]; c = f[3];
        case (code[3:1])
            3'd0: r = z;
            3'd1: r = c;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = c && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return code[0] ? !r : r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        logic [3:0] old, top;
        bit ovs, uns;
        ovs = 1'b0; uns = 1'b0;
        old = m_flags;
        if (bus.push && bus.pop && m_q.size() > 0) begin
            top = m_q[$];
            m_q[$] = old;
            m_flags = top;
        end else if (bus.push) begin
            if (m_q.size() < DEPTH) m_q.push_back(old);
            else ovs = 1'b1;
        end else if (bus.pop) begin
            if (m_q.size() > 0) m_flags = m_q.pop_back();
            else uns = 1'b1;
        end
        if (bus.wr_en) m_flags = (m_flags & ~bus.wr_mask) | (bus.flag_in & bus.wr_mask);
        m_ovf = ovs || (m_ovf && !bus.err_clr);
        m_unf = uns || (m_unf && !bus.err_clr);
    endtask

    task automatic model_clear();
        m_flags = '0;
        m_q.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic drive(input bit ps, input bit pp, input bit we, input logic [3:0] m,
                         input logic [3:0] fi, input bit ec, input logic [3:0] cs);
        bus.push = ps; bus.pop = pp; bus.wr_en = we; bus.wr_mask = m;
        bus.flag_in = fi; bus.err_clr = ec; bus.cond_sel = cs;
    endtask

    // One control cycle: drive after the rising edge, commit at the falling edge.
    task automatic cyc(input bit ps, input bit pp, input bit we, input logic [3:0] m,
                       input logic [3:0] fi, input bit ec, input logic [3:0] cs);
        @(posedge clk); #1;
        drive(ps, pp, we, m, fi, ec, cs);
        @(negedge clk);
        model_step();
        #1;
        drive(0, 0, 0, 4'h0, 4'h0, 0, cs);
    endtask

    task automatic wr(input logic [3:0] v);
        cyc(0, 0, 1, 4'hF, v, 0, 4'd14);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        chk_en = 1'b0;
        drive(0, 0, 0, 4'h0, 4'h0, 0, 4'd0);
        rst_n = 1'b0;
        model_clear();
        @(posedge clk); #3;
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    always @(posedge clk) begin
        if (chk_en) begin
            chk("flags", 32'(bus.flags), 32'(m_flags));
            chk("depth", 32'(bus.depth), 32'(m_q.size()));
            chk("full", 32'(bus.full), 32'(m_q.size() == DEPTH));
            chk("empty", 32'(bus.empty), 32'(m_q.size() == 0));
            chk("ovf_err", 32'(bus.ovf_err), 32'(m_ovf));
            chk("unf_err", 32'(bus.unf_err), 32'(m_unf));
            chk("cond_true", 32'(bus.cond_true), 32'(mcond(bus.cond_sel, m_flags)));
        end
    end

    initial begin
        drive(0, 0, 0, 4'h0, 4'h0, 0, 4'd0);

        // reset state
        do_reset();
        #1;
        chk("rst_flags", 32'(bus.flags), 32'h0);
        chk("rst_depth", 32'(bus.depth), 32'h0);
        chk("rst_empty", 32'(bus.empty), 32'h1);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_errs", 32'({bus.ovf_err, bus.unf_err}), 32'h0);

        // masked write
        cyc(0, 0, 1, 4'b0101, 4'b1111, 0, 4'd0);
        chk("mw_flags", 32'(bus.flags), 32'b0101);
        chk("mw_eq", 32'(bus.cond_true), 32'h1);
        bus.cond_sel = 4'd10; #1 chk("mw_ge", 32'(bus.cond_true), 32'h0);
        bus.cond_sel = 4'd11; #1 chk("mw_lt", 32'(bus.cond_true), 32'h1);
        bus.cond_sel = 4'd12; #1 chk("mw_gt", 32'(bus.cond_true), 32'h0);
        bus.cond_sel = 4'd13; #1 chk("mw_le", 32'(bus.cond_true), 32'h1);

        // push / pop round trip
        do_reset();
        wr(4'b0011);
        cyc(1, 0, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("pp_depth1", 32'(bus.depth), 32'h1);
        wr(4'b1100);
        cyc(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("pp_flags", 32'(bus.flags), 32'b0011);
        chk("pp_depth0", 32'(bus.depth), 32'h0);
        chk("pp_empty", 32'(bus.empty), 32'h1);

        // fill, overflow, clear, drain in LIFO order
        do_reset();
        for (int k = 0; k < 5; k++) begin
            wr(4'(k + 1));
            cyc(1, 0, 0, 4'h0, 4'h0, 0, 4'd0);
        end
        chk("ov_depth", 32'(bus.depth), 32'h4);
        chk("ov_full", 32'(bus.full), 32'h1);
        chk("ov_err", 32'(bus.ovf_err), 32'h1);
        cyc(0, 0, 0, 4'h0, 4'h0, 1, 4'd0);
        chk("ov_clr", 32'(bus.ovf_err), 32'h0);
        for (int k = 4; k >= 1; k--) begin
            cyc(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
            chk("ov_lifo", 32'(bus.flags), 32'(k));
        end
        chk("ov_empty", 32'(bus.empty), 32'h1);

        // empty pop, set beats clear
        do_reset();
        cyc(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("un_err", 32'(bus.unf_err), 32'h1);
        chk("un_flags", 32'(bus.flags), 32'h0);
        chk("un_depth", 32'(bus.depth), 32'h0);
        cyc(0, 1, 0, 4'h0, 4'h0, 1, 4'd0);
        chk("un_setwins", 32'(bus.unf_err), 32'h1);
        cyc(0, 0, 0, 4'h0, 4'h0, 1, 4'd0);
        chk("un_clr", 32'(bus.unf_err), 32'h0);

        // exchange at depth 1
        do_reset();
        wr(4'b1000);
        cyc(1, 0, 0, 4'h0, 4'h0, 0, 4'd0);
        wr(4'b0001);
        cyc(1, 1, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("xc_flags", 32'(bus.flags), 32'b1000);
        chk("xc_depth", 32'(bus.depth), 32'h1);
        cyc(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("xc_entry", 32'(bus.flags), 32'b0001);

        // push+pop on empty acts as a plain push
        cyc(1, 1, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("pe_depth", 32'(bus.depth), 32'h1);
        chk("pe_errs", 32'({bus.ovf_err, bus.unf_err}), 32'h0);

        // pop with masked write
        do_reset();
        wr(4'b0110);
        cyc(1, 0, 0, 4'h0, 4'h0, 0, 4'd0);
        wr(4'b0000);
        cyc(0, 1, 1, 4'b0001, 4'b0001, 0, 4'd0);
        chk("pw_flags", 32'(bus.flags), 32'b0111);

        // asynchronous reset mid-cycle at depth 3
        do_reset();
        cyc(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
        for (int k = 0; k < 3; k++) begin
            wr(4'(4'hA + k));
            cyc(1, 0, 0, 4'h0, 4'h0, 0, 4'd0);
        end
        chk("ar_pre_depth", 32'(bus.depth), 32'h3);
        @(posedge clk); #20;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_depth", 32'(bus.depth), 32'h0);
        chk("ar_flags", 32'(bus.flags), 32'h0);
        chk("ar_errs", 32'({bus.ovf_err, bus.unf_err}), 32'h0);
        chk("ar_empty", 32'(bus.empty), 32'h1);
        model_clear();
        @(posedge clk); #3;
        rst_n = 1'b1;
        chk_en = 1'b1;
        cyc(1, 0, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("ar_after", 32'(bus.depth), 32'h1);
        cyc(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
        chk("ar_after_pop", 32'(bus.flags), 32'h0);

        // full condition-code sweep over all flag values
        for (int f = 0; f < 16; f++) begin
            wr(4'(f));
            for (int cs = 0; cs < 16; cs++) begin
                bus.cond_sel = 4'(cs);
                #1 chk("sweep", 32'(bus.cond_true), 32'(mcond(4'(cs), 4'(f))));
            end
        end

        // random traffic against the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 99) < 40, $urandom_range(0, 99) < 35, $urandom_range(0, 1) == 1,
                4'($urandom), 4'($urandom), $urandom_range(0, 9) == 0, 4'($urandom));
        end
        @(posedge clk); #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/flag_stack_reg.md
# flag_stack_reg

Parametrised processor status-flag register with a last-in/first-out save stack and a branch-condition evaluator. It sits between the ALU flag outputs and the control unit. It captures the negative/overflow/carry/zero results under a per-flag write mask, and saves and restores the live flags across calls and interrupts. It also resolves a 4-bit condition code into a single branch-taken signal.

## Interface
Parameters:
- NFLAGS, default 4, number of flag bits; must be ≥4. Bits 0..3 are Z, N, V, C; higher bits are general-purpose and are not used by condition evaluation.
- DEPTH, default 4, number of save-stack entries; must be ≥1.

Ports:
- Clock and reset: one clock, `clk`. Reset is asynchronous and active-low, `rst_n`.
- clk  in  1  system clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- flag_in  in  NFLAGS  new flag values from the ALU.
- wr_en  in  1  flag write strobe from control.
- wr_mask  in  NFLAGS  per-bit write enable; bit i is written only when wr_en and wr_mask[i] are both 1.
- push  in  1  save the live flags onto the stack.
- pop  in  1  restore the live flags from the stack top.
- err_clr  in  1  clear the sticky error bits.
- cond_sel  in  4  condition code for evaluation.
- flags  out  NFLAGS  live flag register.
- depth  out  $clog2(DEPTH+1)  number of occupied stack entries.
- full  out  1  depth == DEPTH.
- empty  out  1  depth == 0.
- ovf_err  out  1  sticky: a push was attempted while the stack was full.
- unf_err  out  1  sticky: a pop was attempted while the stack was empty.
- cond_true  out  1  combinational result of cond_sel applied to flags.

## Operation
- Reset (rst_n=0, asynchronous): flags=0, depth=0, ovf_err=0, unf_err=0, and all stack entries=0. Consequently empty=1 and full=0.
- Write: on each falling edge, flags[i] takes flag_in[i] wherever wr_en and wr_mask[i] are both 1. Unmasked bits hold their value.
- Push (push=1, pop=0):
  - If the stack is not full, the current flags value (the value before any same-edge write) is stored at entry[depth], and depth increments.
  - If the stack is full, the push is dropped, the stack is unchanged, and ovf_err is set.
- Pop (pop=1, push=0):
  - If the stack is not empty, flags are loaded from entry[depth-1], and depth decrements.
  - If the stack is empty, the pop is dropped, flags are unchanged, and unf_err is set.
- Pop with wr_en on the same edge: the restored value is loaded first, then masked write bits override it. The ALU result therefore wins on masked bits.
- Push and pop on the same edge:
  - If depth>0, this is an exchange: entry[depth-1] takes the pre-edge flags, flags take the old entry[depth-1], and depth is unchanged. Any wr_en then overrides masked bits.
  - If depth=0, it behaves as a push alone, with no error.
- Errors: ovf_err and unf_err are sticky until err_clr. If a set condition and err_clr occur on the same edge, the set wins.
- Condition codes, with cond_sel → cond_true (Z=flags[0], N=flags[1], V=flags[2], C=flags[3]):
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 MI: N
  - 5 PL: !N
  - 6 VS: V
  - 7 VC: !V
  - 8 HI: C&!Z
  - 9 LS: !C|Z
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 GT: !Z&(N==V)
  - 13 LE: Z|(N!=V)
  - 14 AL: 1
  - 15 NV: 0

## Timing
- All state changes on negedge clk, matching the CPU control phase. Control strobes are sampled at that edge.
- Write, push and pop latency: the new flags and depth are visible immediately after the falling edge. A pushed value becomes poppable on the next falling edge.
- cond_true is combinational from the registered flags; it adds zero cycles and has no path from flag_in.
- full, empty and depth are registered-derived, with no combinational path from push or pop.
- Reset mid-operation: an in-flight push, pop or write is abandoned, and all outputs go to their reset values asynchronously. The first edge after release operates normally.
- Pointer boundaries: depth never exceeds DEPTH and never wraps below 0.

## Structure
- Shared package flag_pkg holds:
  - Flag index constants FLAG_Z=0, FLAG_N=1, FLAG_V=2, FLAG_C=3.
  - The 4-bit condition-code enum (EQ..NV).
  - These are shared with the decoder and the branch unit.
- Sub-module flag_cond_eval: a purely combinational cond_sel/flags → cond_true decoder, reused by the branch unit.
- The stack is an array of DEPTH×NFLAGS registers indexed by depth; there is no separate read pointer.

## Test plan
- Masked write: reset, then wr_en=1, wr_mask=4'b0101, flag_in=4'b1111 → flags=4'b0101; cond_sel=EQ → cond_true=1.
- Push/pop: DEPTH=4; push with flags=4'b0011, write 4'b1100 (full mask), then pop → flags=4'b0011, depth 1→0, empty=1.
- Full and overflow: 5 pushes with DEPTH=4 → depth=4, full=1, ovf_err=1, entries unchanged. Then err_clr=1 → ovf_err=0. Then pop 4 times → LIFO order is preserved.
- Empty pop: pop at reset → unf_err=1, flags=0, depth=0. Next, err_clr together with another empty pop → unf_err stays 1.
- Simultaneous events:
  - push+pop at depth=1, entry=4'b1000, flags=4'b0001 → flags=4'b1000, entry=4'b0001, depth=1.
  - pop+wr_en with mask 4'b0001 and flag_in=4'b0001 → bit0=1 and the rest come from the stack.
- Async reset: assert rst_n=0 mid-cycle at depth=3 → depth, flags and errors are 0 before the next edge. Also sweep all 16 cond_sel codes against the N,V combinations for GE/LT/GT/LE.
